// File: rtl/rstn_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding,
// default parameter values and counter sizing helper.
package rstn_seq_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        HOLD  = 2'd1,
        STAGE = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam int SYNC_DEPTH_DEF = 2;
    localparam int HOLD_CYC_DEF   = 16;
    localparam int GAP_CYC_DEF    = 4;
    localparam int NSTAGE_DEF     = 3;

    // Width able to hold max(a,b) without wrapping; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rstn_sync.sv
// Reset synchronizer: asynchronous assertion, DEPTH-flop synchronous
// deassertion. Output goes high after the DEPTH-th rising edge with rstn high.
module rstn_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    output logic o_rstn_sync
);

    logic [DEPTH-1:0] r_chain;

    // Shift ones in after release; clear the whole chain the instant rstn drops.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], 1'b1};
        end
    end

    assign o_rstn_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/rstn_sequencer.sv
// Staged reset sequencer. After a synchronized release of rstn, all stages
// are held for HOLD_CYC cycles, then released one by one (bit 0 first) with
// GAP_CYC idle cycles between releases; rst_done rises with the last one.
// Optional soft reset (compile-time macro RSTN_SEQ_SOFT_EN): soft_req sampled
// in RUN drops every stage and replays the hold/stage sequence without the
// synchronizer delay, ending with a one-cycle soft_ack.
module rstn_sequencer
    import rstn_seq_pkg::*;
#(
    parameter int SYNC_DEPTH = SYNC_DEPTH_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF,
    parameter int NSTAGE     = NSTAGE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              soft_req,
    output logic [NSTAGE-1:0] stage_rstn,
    output logic              rst_done,
    output logic              soft_ack
);

    localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
    localparam int IDX_W = (NSTAGE < 2) ? 1 : $clog2(NSTAGE);

    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 1);

    logic              w_sync_rstn;

    state_e            r_state,  w_state_nx;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nx;
    logic [IDX_W-1:0]  r_idx,    w_idx_nx;
    logic [NSTAGE-1:0] r_stage,  w_stage_nx;
    logic              r_done,   w_done_nx;
    logic              w_rel;
    logic [IDX_W-1:0]  w_rel_idx;
`ifdef RSTN_SEQ_SOFT_EN
    logic              w_soft_go;
    logic              r_soft;
    logic              r_ack;
`else
    logic              w_unused_soft_req;
`endif

    rstn_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .o_rstn_sync (w_sync_rstn)
    );

    // State, counters and output flops; rstn low clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= SYNC;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_stage <= w_stage_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next-state logic. A "release" of stage k is requested via w_rel/w_rel_idx
    // and applied after the case so SYNC, HOLD and STAGE share one path.
    // Power-on HOLD preloads the counter with 1 because the SYNC cycle that
    // observed the synchronized release already counts; soft HOLD starts at 0
    // since the soft request edge plays that role instead.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_stage_nx = r_stage;
        w_done_nx  = r_done;
        w_rel      = 1'b0;
        w_rel_idx  = '0;
`ifdef RSTN_SEQ_SOFT_EN
        w_soft_go  = 1'b0;
`endif
        case (r_state)
            SYNC: begin
                if (w_sync_rstn) begin
                    if (HOLD_CYC == 0) begin
                        w_rel = 1'b1;
                    end else begin
                        w_state_nx = HOLD;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_C) begin
                    w_rel = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            STAGE: begin
                if (r_cnt == GAP_C) begin
                    w_rel     = 1'b1;
                    w_rel_idx = r_idx + IDX_W'(1);
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
`ifdef RSTN_SEQ_SOFT_EN
                if (soft_req) begin
                    w_soft_go  = 1'b1;
                    w_state_nx = HOLD;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_stage_nx = '0;
                    w_done_nx  = 1'b0;
                end
`endif
            end
            default: begin
                w_state_nx = SYNC;
            end
        endcase

        if (w_rel) begin
            for (int i = 0; i < NSTAGE; i++) begin
                if (IDX_W'(i) == w_rel_idx) begin
                    w_stage_nx[i] = 1'b1;
                end
            end
            w_idx_nx = w_rel_idx;
            w_cnt_nx = '0;
            if (w_rel_idx == LAST_IDX) begin
                w_state_nx = RUN;
                w_done_nx  = 1'b1;
            end else begin
                w_state_nx = STAGE;
            end
        end
    end

`ifdef RSTN_SEQ_SOFT_EN
    // Track an in-flight soft reset and pulse soft_ack on the edge it re-enters RUN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_soft <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= r_soft && (r_state != RUN) && (w_state_nx == RUN);
            if (w_soft_go) begin
                r_soft <= 1'b1;
            end else if (w_state_nx == RUN) begin
                r_soft <= 1'b0;
            end
        end
    end

    assign soft_ack = r_ack;
`else
    assign w_unused_soft_req = soft_req;
    assign soft_ack          = 1'b0;
`endif

    assign stage_rstn = r_stage;
    assign rst_done   = r_done;

endmodule

// File: tb/tb_rstn_sequencer.sv
// Bench for rstn_sequencer: a default instance and a HOLD=0/GAP=0/NSTAGE=4
// instance share clk/rstn. Stimulus pushes expected output changes
// (cycle, value) into per-instance queues; a monitor compares every change.
module tb_rstn_sequencer;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic       soft_req = 1'b0;
    logic [2:0] st1;
    logic       done1, ack1;
    logic [3:0] st2;
    logic       done2, ack2;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    logic [7:0] prev1 = '0;
    logic [7:0] prev2 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rstn_sequencer dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .soft_req   (soft_req),
        .stage_rstn (st1),
        .rst_done   (done1),
        .soft_ack   (ack1)
    );

    rstn_sequencer #(
        .HOLD_CYC (0),
        .GAP_CYC  (0),
        .NSTAGE   (4)
    ) dut2 (
        .clk        (clk),
        .rstn       (rstn),
        .soft_req   (1'b0),
        .stage_rstn (st2),
        .rst_done   (done2),
        .soft_ack   (ack2)
    );

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input int id, input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        if (id == 1) q1.push_back(e);
        else         q2.push_back(e);
    endtask

    // dut1 value = {st[2:0], done, ack}; power-on releases after edges 19/24/29
    task automatic po1(input int b);
        push(1, b + 19, 8'b000_001_0_0);
        push(1, b + 24, 8'b000_011_0_0);
        push(1, b + 29, 8'b000_111_1_0);
    endtask

    // dut2 value = {st[3:0], done, ack}; releases after edges 3/4/5/6
    task automatic po2(input int b);
        push(2, b + 3, 8'b00_0001_0_0);
        push(2, b + 4, 8'b00_0011_0_0);
        push(2, b + 5, 8'b00_0111_0_0);
        push(2, b + 6, 8'b00_1111_1_0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change on an instance's outputs must match the next expected entry.
    always @(negedge clk) begin
        logic [7:0] v1, v2;
        exp_t       e;
        v1 = {3'b000, st1, done1, ack1};
        v2 = {2'b00, st2, done2, ack2};
        if (v1 != prev1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected: got %b at cyc %0d, expected no change", v1, cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1_evt_cyc", cyc, e.cyc);
                chk("dut1_evt_val", int'(v1), int'(e.val));
            end
            prev1 = v1;
        end
        if (v2 != prev2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_unexpected: got %b at cyc %0d, expected no change", v2, cyc);
            end else begin
                e = q2.pop_front();
                chk("dut2_evt_cyc", cyc, e.cyc);
                chk("dut2_evt_val", int'(v2), int'(e.val));
            end
            prev2 = v2;
        end
    end

    initial begin
        int c0;
        int s;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_st1",   int'(st1),   0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_ack1",  int'(ack1),  0);
        chk("rst_st2",   int'(st2),   0);

        // Release, then abort dut1 mid-HOLD at edge 10 (dut2 already in RUN)
        c0 = cyc;
        po2(c0);
        rstn = 1'b1;
        wait_to(c0 + 9);
        chk("hold_st1", int'(st1), 0);
        #2 rstn = 1'b0;
        push(2, cyc + 1, 8'h00);
        #1;
        chk("async_st2",   int'(st2),   0);
        chk("async_done2", int'(done2), 0);
        repeat (2) @(negedge clk);
        c0 = cyc;
        po1(c0);
        po2(c0);
        rstn = 1'b1;
        wait_to(c0 + 35);
        chk("run_st1", int'(st1), 7);

        // Abort from RUN: outputs must clear without a clock edge
        #2 rstn = 1'b0;
        push(1, cyc + 1, 8'h00);
        push(2, cyc + 1, 8'h00);
        #1;
        chk("async_st1",   int'(st1),   0);
        chk("async_done1", int'(done1), 0);
        repeat (2) @(negedge clk);
        c0 = cyc;
        po1(c0);
        po2(c0);
        rstn = 1'b1;
        wait_to(c0 + 35);

`ifdef RSTN_SEQ_SOFT_EN
        // Single soft reset, request dropped once ack is seen
        s = cyc + 1;
        soft_req = 1'b1;
        push(1, s,      8'b000_000_0_0);
        push(1, s + 17, 8'b000_001_0_0);
        push(1, s + 22, 8'b000_011_0_0);
        push(1, s + 27, 8'b000_111_1_1);
        push(1, s + 28, 8'b000_111_1_0);
        wait_to(s + 27);
        soft_req = 1'b0;
        wait_to(s + 40);

        // Request held through ack: second soft reset starts the next edge
        s = cyc + 1;
        soft_req = 1'b1;
        push(1, s,      8'b000_000_0_0);
        push(1, s + 17, 8'b000_001_0_0);
        push(1, s + 22, 8'b000_011_0_0);
        push(1, s + 27, 8'b000_111_1_1);
        push(1, s + 28, 8'b000_000_0_0);
        push(1, s + 45, 8'b000_001_0_0);
        push(1, s + 50, 8'b000_011_0_0);
        push(1, s + 55, 8'b000_111_1_1);
        push(1, s + 56, 8'b000_111_1_0);
        wait_to(s + 28);
        soft_req = 1'b0;
        wait_to(s + 65);

        // Pulse during STAGE must be ignored
        s = cyc + 1;
        soft_req = 1'b1;
        push(1, s,      8'b000_000_0_0);
        push(1, s + 17, 8'b000_001_0_0);
        push(1, s + 22, 8'b000_011_0_0);
        push(1, s + 27, 8'b000_111_1_1);
        push(1, s + 28, 8'b000_111_1_0);
        @(negedge clk);
        soft_req = 1'b0;
        wait_to(s + 19);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        wait_to(s + 40);
        chk("soft_end_st1", int'(st1), 7);
`else
        // Soft reset compiled out: request in RUN changes nothing
        soft_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("nosoft_st1",  int'(st1),  7);
        chk("nosoft_ack1", int'(ack1), 0);
        soft_req = 1'b0;
        s = cyc;
        wait_to(s + 5);
`endif

        repeat (5) @(negedge clk);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
